// File: rtl/rca3_arb_pkg.sv
// Shared constants, state type and the 3-operand sum helper for the rca3 round-robin arbiter.
package rca3_arb_pkg;

  localparam int OP_W  = 16;
  localparam int SUM_W = 18;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } rca3_arb_state_e;

  // Zero-extend every term first so the sum is exact (max 3*65535+1 = 196606).
  function automatic logic [SUM_W-1:0] add3(input logic [OP_W-1:0] a,
                                            input logic [OP_W-1:0] b,
                                            input logic [OP_W-1:0] c,
                                            input logic            cin);
    return SUM_W'(a) + SUM_W'(b) + SUM_W'(c) + SUM_W'(cin);
  endfunction

endpackage

// File: rtl/rca3_rr_arbiter_rr.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping to 0.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    idx
);

  logic found;
  int   k;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    k     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = (int'(ptr) + i) % NUM_REQ;
      if (en && !found && req[k]) begin
        found  = 1'b1;
        gnt[k] = 1'b1;
        idx    = ID_W'(k);
      end
    end
  end

endmodule

// File: rtl/rca3_rr_arbiter.sv
// Shares one 3-operand adder among NUM_REQ requesters and stages the result in a one-entry register.
// Define RCA3_ARB_PRIO0_EN to give requester 0 strict priority over the round-robin.
module rca3_rr_arbiter
  import rca3_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*OP_W-1:0] req_a,
  input  logic [NUM_REQ*OP_W-1:0] req_b,
  input  logic [NUM_REQ*OP_W-1:0] req_c,
  input  logic [NUM_REQ-1:0]      req_cin,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [SUM_W-1:0]        rsp_sum,
  output logic [ID_W-1:0]         rsp_id
);

  rca3_arb_state_e    state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic [ID_W-1:0]    id_q, id_d;

  logic               can_accept;
  logic               prio0;
  logic               xfer;
  logic [NUM_REQ-1:0] arb_gnt;
  logic [ID_W-1:0]    arb_idx;
  logic [NUM_REQ-1:0] gnt_vec;
  logic [ID_W-1:0]    gnt_idx;
  logic [OP_W-1:0]    a_sel, b_sel, c_sel;
  logic               cin_sel;

  assign rsp_valid  = (state_q == FULL);
  assign can_accept = (state_q == EMPTY) | (rsp_ready & rsp_valid);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .en  (can_accept),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

`ifdef RCA3_ARB_PRIO0_EN
  assign prio0 = can_accept & req_valid[0];
`else
  assign prio0 = 1'b0;
`endif

  assign gnt_vec   = prio0 ? NUM_REQ'(1) : arb_gnt;
  assign gnt_idx   = prio0 ? '0 : arb_idx;
  assign req_ready = gnt_vec;
  assign xfer      = |(req_valid & gnt_vec);

  assign a_sel   = req_a[OP_W*int'(gnt_idx) +: OP_W];
  assign b_sel   = req_b[OP_W*int'(gnt_idx) +: OP_W];
  assign c_sel   = req_c[OP_W*int'(gnt_idx) +: OP_W];
  assign cin_sel = req_cin[gnt_idx];

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    sum_d    = sum_q;
    id_d     = id_q;
    if (xfer) begin
      state_d = FULL;
      sum_d   = add3(a_sel, b_sel, c_sel, cin_sel);
      id_d    = gnt_idx;
      // Priority grants to requester 0 leave the round-robin position untouched.
      if (!prio0) begin
        rr_ptr_d = (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
      end
    end else if ((state_q == FULL) && rsp_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      rr_ptr_q <= '0;
      sum_q    <= '0;
      id_q     <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      sum_q    <= sum_d;
      id_q     <= id_d;
    end
  end

  assign rsp_sum = sum_q;
  assign rsp_id  = id_q;

endmodule
